// File: rtl/mul_acc_frame.sv
// rtl/mul_acc_frame.sv - frame accumulator for the 8-bit product stream; MAC_OVF_EN adds saturation and acc_ovf
module mul_acc_frame #(
    parameter int LEN   = 4,
    parameter int ACC_W = 10,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       prod,
    input  logic             prod_valid,
    input  logic             prod_last,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] acc_cnt,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MAC_OVF_EN
    ,
    output logic             acc_ovf
`endif
);

    typedef enum logic {S_ACCUM, S_HOLD} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc_out;
    logic [CNT_W-1:0] r_acc_cnt;
    logic             w_xfer;
    logic             w_end;
    logic [ACC_W-1:0] w_acc_nxt;

    assign w_xfer = prod_valid && (r_state == S_ACCUM);
    assign w_end  = w_xfer && (prod_last || (r_cnt == CNT_W'(LEN - 1)));

`ifdef MAC_OVF_EN
    logic             r_ovf;
    logic             r_acc_ovf;
    logic [ACC_W:0]   w_sum;
    logic             w_ovf_nxt;

    // once a carry has been seen the sum is pinned at all-ones for the rest of the frame
    assign w_sum     = {1'b0, r_acc} + (ACC_W + 1)'(prod);
    assign w_ovf_nxt = r_ovf | w_sum[ACC_W];
    assign w_acc_nxt = w_ovf_nxt ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    assign acc_ovf   = r_acc_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf     <= 1'b0;
            r_acc_ovf <= 1'b0;
        end else if (w_end) begin
            r_ovf     <= 1'b0;
            r_acc_ovf <= w_ovf_nxt;
        end else if (w_xfer) begin
            r_ovf     <= w_ovf_nxt;
        end
    end
`else
    assign w_acc_nxt = r_acc + ACC_W'(prod);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ACCUM;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ACCUM: if (w_end) w_next = S_HOLD;
            S_HOLD:  if (out_ready) w_next = S_ACCUM;
            default: w_next = S_ACCUM;
        endcase
    end

    // handshake outputs come from the state register only, never from out_ready
    always_comb begin
        prod_ready = 1'b0;
        out_valid  = 1'b0;
        case (r_state)
            S_ACCUM: prod_ready = 1'b1;
            S_HOLD:  out_valid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_acc_out <= '0;
            r_acc_cnt <= '0;
        end else if (w_end) begin
            r_acc_out <= w_acc_nxt;
            r_acc_cnt <= r_cnt + 1'b1;
            r_acc     <= '0;
            r_cnt     <= '0;
        end else if (w_xfer) begin
            r_acc     <= w_acc_nxt;
            r_cnt     <= r_cnt + 1'b1;
        end
    end

    assign acc_out = r_acc_out;
    assign acc_cnt = r_acc_cnt;

endmodule

// File: tb/tb_mul_acc_frame.sv
// tb/tb_mul_acc_frame.sv - table, directed and random checks of mul_acc_frame
module tb_mul_acc_frame;

    localparam int LEN   = 4;
`ifdef MAC_OVF_EN
    localparam int ACC_W = 8;
`else
    localparam int ACC_W = 10;
`endif
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       prod = '0;
    logic             prod_valid = 1'b0;
    logic             prod_last = 1'b0;
    logic             prod_ready;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] acc_cnt;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             ovf_seen;
`ifdef MAC_OVF_EN
    logic             acc_ovf;
    assign ovf_seen = acc_ovf;
`else
    assign ovf_seen = 1'b0;
`endif

    mul_acc_frame #(.LEN(LEN), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_last  (prod_last),
        .prod_ready (prod_ready),
        .acc_out    (acc_out),
        .acc_cnt    (acc_cnt),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef MAC_OVF_EN
        ,
        .acc_ovf    (acc_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int p[4];
        int n;
        bit last;
        int gap;
        int es;
        int ec;
        bit eo;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input int a, b, c, d, input int n, input bit last,
                                 input int gap, input int es, input int ec, input bit eo);
        vec_t v;
        v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
        v.n = n; v.last = last; v.gap = gap; v.es = es; v.ec = ec; v.eo = eo;
        return v;
    endfunction

    // inputs change and outputs are sampled on the falling edge
    task automatic push(input int p, input bit last);
        int n = 0;
        prod = 8'(p); prod_last = last; prod_valid = 1'b1;
        while (!prod_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("push_timeout", 0, 1);
        @(negedge clk);
        prod_valid = 1'b0; prod_last = 1'b0;
    endtask

    task automatic get_result(input string name, input int es, input int ec, input bit eo);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_sum"}, acc_out, es);
        chk({name, "_cnt"}, acc_cnt, ec);
`ifdef MAC_OVF_EN
        chk({name, "_ovf"}, ovf_seen, eo);
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_drop"}, out_valid, 0);
        chk({name, "_ready"}, prod_ready, 1);
    endtask

    task automatic send(input vec_t v);
        for (int k = 0; k < v.n; k++) begin
            push(v.p[k], v.last && (k == v.n - 1));
            if (k != v.n - 1) repeat (v.gap) @(negedge clk);
        end
        chk("latency_valid", out_valid, 1);
        chk("hold_ready", prod_ready, 0);
    endtask

    initial begin
        int maxv;
        maxv = (1 << ACC_W) - 1;

`ifdef MAC_OVF_EN
        tbl.push_back(mkv(200, 100, 5, 5, 4, 0, 0, 255, 4, 1));
        tbl.push_back(mkv(1, 1, 1, 1, 4, 0, 0, 4, 4, 0));
        tbl.push_back(mkv(225, 225, 0, 0, 2, 1, 0, 255, 2, 1));
`else
        tbl.push_back(mkv(225, 225, 225, 225, 4, 0, 0, 900, 4, 0));
`endif
        tbl.push_back(mkv(6, 35, 0, 0, 2, 1, 0, 41, 2, 0));
        tbl.push_back(mkv(1, 1, 1, 1, 4, 0, 0, 4, 4, 0));
        tbl.push_back(mkv(1, 2, 3, 4, 4, 0, 2, 10, 4, 0));
        tbl.push_back(mkv(9, 0, 0, 0, 1, 1, 0, 9, 1, 0));
        tbl.push_back(mkv(17, 4, 100, 0, 3, 1, 1, 121, 3, 0));

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_prod_ready", prod_ready, 1);
        chk("rst_acc_out", acc_out, 0);
        chk("rst_acc_cnt", acc_cnt, 0);
`ifdef MAC_OVF_EN
        chk("rst_acc_ovf", ovf_seen, 0);
`endif

        foreach (tbl[i]) begin
            send(tbl[i]);
            get_result($sformatf("tbl%0d", i), tbl[i].es, tbl[i].ec, tbl[i].eo);
        end

        // backpressure: result held while a new product waits
        push(10, 0); push(20, 0); push(30, 0); push(40, 0);
        prod = 8'd99; prod_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", acc_out, 100);
            chk("bp_ready", prod_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_drop", out_valid, 0);
        chk("bp_ready_back", prod_ready, 1);
        @(negedge clk);
        prod_valid = 1'b0;
        push(1, 1);
        get_result("bp_next", 100, 2, 0);

        // reset mid-frame discards the partial sum
        push(50, 0); push(60, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", out_valid, 0);
        rst = 1'b0;
        chk("midrst_valid2", out_valid, 0);
        for (int k = 0; k < 4; k++) push(7, 0);
        get_result("midrst", 28, 4, 0);

        for (int f = 0; f < 40; f++) begin
            int n, sum;
            bit last;
            int ps[$];
            n = $urandom_range(1, LEN);
            last = (n < LEN) ? 1'b1 : 1'($urandom_range(0, 1));
            sum = 0;
            for (int k = 0; k < n; k++) begin
                ps.push_back($urandom_range(0, 255));
                sum += ps[k];
            end
            for (int k = 0; k < n; k++) begin
                push(ps[k], last && (k == n - 1));
                if (k != n - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            repeat ($urandom_range(0, 3)) begin
                chk("rnd_hold", out_valid, 1);
                @(negedge clk);
            end
`ifdef MAC_OVF_EN
            get_result($sformatf("rnd%0d", f), (sum > maxv) ? maxv : sum, n, sum > maxv);
`else
            get_result($sformatf("rnd%0d", f), sum % (maxv + 1), n, 0);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
